// File: rtl/apogeo_pkg.sv
// Shared global widths for the core.
//   ADDRESS_WIDTH : byte address width of the data-memory side
//   DATA_WIDTH    : width of one data word
package apogeo_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

endpackage : apogeo_pkg

// File: rtl/data_memory_pkg.sv
// Data-memory types shared by the load/store path and the store buffer.
//   data_word_t          : one data word
//   address_t            : one memory address
//   store_width_t        : store size tag (BYTE=0, HALF=1, WORD=2)
//   store_buffer_entry_t : one buffered store, {data, address, store_width} MSB first
package data_memory_pkg;

  import apogeo_pkg::*;

  typedef logic [DATA_WIDTH-1:0]    data_word_t;
  typedef logic [ADDRESS_WIDTH-1:0] address_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } store_width_t;

  typedef struct packed {
    data_word_t   data;
    address_t     address;
    store_width_t store_width;
  } store_buffer_entry_t;

endpackage : data_memory_pkg

// File: rtl/store_buffer_if.sv
// Channel interfaces of the store buffer.
//   store_buffer_push_interface : packet + push_request from the LSU, full back to it
//   store_buffer_pull_interface : head packet + empty to the memory port, pull_request from it
// The master modport is the side that drives the request.
interface store_buffer_push_interface;

  import data_memory_pkg::*;

  store_buffer_entry_t packet;
  logic                push_request;
  logic                full;

  modport master (output packet, output push_request, input  full);
  modport slave  (input  packet, input  push_request, output full);

endinterface : store_buffer_push_interface

interface store_buffer_pull_interface;

  import data_memory_pkg::*;

  store_buffer_entry_t packet;
  logic                pull_request;
  logic                empty;

  modport master (input  packet, output pull_request, input  empty);
  modport slave  (output packet, input  pull_request, output empty);

endinterface : store_buffer_pull_interface

// File: rtl/store_buffer.sv
// Write-back store buffer between the load/store unit and the data-memory port.
// Stores are held in a circular FIFO and drained oldest first; a store to an
// already buffered address with the same width overwrites that entry's data.
// Loads are forwarded combinationally from the youngest entry with that address.
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   push_channel       : incoming stores, full flag
//   pull_channel       : head entry (first-word fall-through), pop request, empty flag
//   merge_done_o       : one-cycle pulse after a store merged into an existing entry
//   foward_address_i   : load address to look up
//   foward_data_o      : data of the youngest matching entry (0 on miss)
//   address_match_o    : load address hits a valid entry
module store_buffer
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  store_buffer_push_interface.slave          push_channel,
  store_buffer_pull_interface.slave          pull_channel,
  output logic                               merge_done_o,
  input  address_t                           foward_address_i,
  output data_word_t                         foward_data_o,
  output logic                               address_match_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  store_buffer_entry_t entries [DEPTH];
  logic [DEPTH-1:0]    valid;
  ptr_t                wr_ptr;
  ptr_t                rd_ptr;
  cnt_t                count;

  logic full;
  logic empty;
  logic pop;
  logic merge_hit;
  ptr_t merge_idx;
  logic alloc;

  assign full  = (count == cnt_t'(DEPTH));
  assign empty = (count == '0);
  assign pop   = pull_channel.pull_request && !empty;

  // Merge candidate: same address and width, but never the head that leaves on
  // this edge. At most one entry can qualify because earlier stores merged.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]
          && entries[i].address == push_channel.packet.address
          && entries[i].store_width == push_channel.packet.store_width
          && !(pop && ptr_t'(i) == rd_ptr)) begin
        merge_hit = 1'b1;
        merge_idx = ptr_t'(i);
      end
    end
  end

  // A miss when full is only accepted if the head pops on the same edge; the
  // write pointer then equals the freed head slot.
  assign alloc = push_channel.push_request && !merge_hit && (!full || pop);

  // NOTE: the entry array carries no reset; the valid bits alone define which contents are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_channel.push_request && merge_hit) begin
      entries[merge_idx].data <= push_channel.packet.data;
    end else if (alloc) begin
      entries[wr_ptr] <= push_channel.packet;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      merge_done_o <= 1'b0;
    end else begin
      merge_done_o <= push_channel.push_request && merge_hit;
      // Clear before set: when full with push+pull the same slot is freed and refilled.
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + ptr_t'(1);
      end
      if (alloc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + ptr_t'(1);
      end
      if (alloc && !pop) begin
        count <= count + cnt_t'(1);
      end else if (pop && !alloc) begin
        count <= count - cnt_t'(1);
      end
    end
  end

  assign push_channel.full  = full;
  assign pull_channel.empty = empty;
  assign pull_channel.packet = empty ? '0 : entries[rd_ptr];

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    address_match_o = 1'b0;
    foward_data_o   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[rd_ptr + ptr_t'(k)]
          && entries[rd_ptr + ptr_t'(k)].address == foward_address_i) begin
        address_match_o = 1'b1;
        foward_data_o   = entries[rd_ptr + ptr_t'(k)].data;
      end
    end
  end

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model. Pulled packets are
// checked by a separate monitor against a scoreboard queue.
module tb_store_buffer;

  import data_memory_pkg::*;

  localparam int DEPTH = 4;

  logic       clk_i;
  logic       rst_n_i;
  logic       merge_done_o;
  address_t   foward_address_i;
  data_word_t foward_data_o;
  logic       address_match_o;

  store_buffer_push_interface push_if ();
  store_buffer_pull_interface pull_if ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .push_channel     (push_if),
    .pull_channel     (pull_if),
    .merge_done_o     (merge_done_o),
    .foward_address_i (foward_address_i),
    .foward_data_o    (foward_data_o),
    .address_match_o  (address_match_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the buffered stores, oldest at index 0.
  store_buffer_entry_t model_q [$];
  // Scoreboard: packets the memory port should receive, in order.
  store_buffer_entry_t sb_q [$];
  bit exp_merge = 1'b0;

  task automatic check(input string name, input logic [65:0] actual, input logic [65:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every accepted pull must match the next scoreboard entry.
  always @(negedge clk_i) begin
    if (rst_n_i && pull_if.pull_request === 1'b1 && pull_if.empty === 1'b0) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL pull_unexpected: got %h expected no packet at %0t", pull_if.packet, $time);
      end else begin
        check("pull_packet", pull_if.packet, sb_q.pop_front());
      end
    end
  end

  // One clock cycle: drive inputs (just after a rising edge), check outputs at
  // the falling edge against the model, then advance the model across the edge.
  task automatic step(input bit do_push, input data_word_t data, input address_t addr,
                      input store_width_t w, input bit do_pull, input address_t fa);
    store_buffer_entry_t p;
    bit         exp_match;
    data_word_t exp_data;
    int         hit;
    int         size_before;
    bit         popped;

    p.data        = data;
    p.address     = addr;
    p.store_width = w;
    push_if.packet       = p;
    push_if.push_request = do_push;
    pull_if.pull_request = do_pull;
    foward_address_i     = fa;

    exp_match = 1'b0;
    exp_data  = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].address == fa) begin
        exp_match = 1'b1;
        exp_data  = model_q[i].data;
        break;
      end
    end
    if (do_pull && model_q.size() > 0) sb_q.push_back(model_q[0]);

    @(negedge clk_i);
    check("full", {65'd0, push_if.full}, {65'd0, model_q.size() == DEPTH});
    check("empty", {65'd0, pull_if.empty}, {65'd0, model_q.size() == 0});
    check("address_match", {65'd0, address_match_o}, {65'd0, exp_match});
    check("foward_data", {34'd0, foward_data_o}, {34'd0, exp_data});
    check("merge_done", {65'd0, merge_done_o}, {65'd0, exp_merge});
    if (model_q.size() == 0) check("pull_packet_empty", pull_if.packet, 66'd0);
    else                     check("pull_head", pull_if.packet, model_q[0]);

    // Model update for the coming edge.
    size_before = model_q.size();
    popped      = do_pull && size_before > 0;
    hit         = -1;
    if (do_push) begin
      for (int i = 0; i < size_before; i++) begin
        if (!(i == 0 && popped) && model_q[i].address == addr && model_q[i].store_width == w)
          hit = i;
      end
    end
    if (hit >= 0) model_q[hit].data = data;
    exp_merge = (hit >= 0);
    if (popped) void'(model_q.pop_front());
    if (do_push && hit < 0 && (size_before < DEPTH || popped)) model_q.push_back(p);

    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input address_t fa);
    step(1'b0, '0, '0, BYTE, 1'b0, fa);
  endtask

  data_word_t d [5];

  initial begin
    for (int i = 0; i < 5; i++) d[i] = 32'hA000_0000 + 32'(i * 32'h1111);

    rst_n_i              = 1'b0;
    push_if.packet       = '0;
    push_if.push_request = 1'b0;
    pull_if.pull_request = 1'b0;
    foward_address_i     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_empty", {65'd0, pull_if.empty}, 66'd1);
    check("rst_full", {65'd0, push_if.full}, 66'd0);
    check("rst_merge_done", {65'd0, merge_done_o}, 66'd0);
    check("rst_address_match", {65'd0, address_match_o}, 66'd0);
    check("rst_foward_data", {34'd0, foward_data_o}, 66'd0);
    check("rst_pull_packet", pull_if.packet, 66'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill with four WORD stores to addresses 0..3.
    for (int i = 0; i < 4; i++) step(1'b1, d[i], address_t'(i), WORD, 1'b0, '0);
    // Forward hit and miss.
    idle(32'd2);
    idle(32'd7);
    // Merge while full, then a dropped miss while full.
    step(1'b1, d[4], 32'd1, WORD, 1'b0, 32'd1);
    idle(32'd1);
    step(1'b1, 32'hDEAD_BEEF, 32'd9, WORD, 1'b0, 32'd9);
    idle(32'd9);
    // Drain with four pulls plus one extra on empty.
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, BYTE, 1'b1, 32'd1);
    idle(32'd3);

    // Concurrency: three entries, then push+pull together until pointers wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hB000_0000 + 32'(i), 32'd10 + 32'(i), HALF, 1'b0, '0);
    for (int i = 3; i < 9; i++) step(1'b1, 32'hB000_0000 + 32'(i), 32'd10 + 32'(i), HALF, 1'b1, 32'd12);
    // Merge with the head popping on the same edge must allocate instead.
    step(1'b1, 32'hC0DE_0001, 32'd16, HALF, 1'b1, 32'd16);
    idle(32'd16);

    // Random traffic on a small address range so merges and full/empty happen often.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 60, $urandom(), address_t'($urandom_range(0, 7)),
           store_width_t'($urandom_range(0, 2)), $urandom_range(0, 99) < 45,
           address_t'($urandom_range(0, 8)));
    end

    // Drain whatever is left.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, '0, BYTE, 1'b1, '0);
    idle('0);
    check("scoreboard_drained", 66'(sb_q.size()), 66'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_store_buffer
